inv_key_expand: RTL

- Iterative AES-128 inverse key scheduler: the reverse direction of the forward subkey generator (GenSubKey).
- Loaded with the round-10 key, it walks the schedule backwards and emits round keys 10, 9, ..., 0, one per accepted handshake.
- Feeds the decryption datapath, so no full key-schedule RAM is needed.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/inv_key_step.sv | 22 ++
 rtl/inv_key_expand.sv | 115 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, S-box, word helpers, the backwards rcon
// sequence and the inverse-scheduler FSM state type.
package aes_pkg;

  localparam int KEY_LEN    = 128;
  localparam int WORD_LEN   = 32;
  localparam int NUM_ROUNDS = 10;

  localparam logic [7:0] RCON_LAST = 8'h36;

  typedef enum logic {IDLE, EMIT} state_e;

  // Byte 0x00 lives in the top eight bits of the table.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [WORD_LEN-1:0] sub_word(input logic [WORD_LEN-1:0] w);
    logic [WORD_LEN-1:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox(w[i*8 +: 8]);
    return r;
  endfunction

  function automatic logic [WORD_LEN-1:0] rot_word(input logic [WORD_LEN-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Walks rcon backwards: 36 -> 1B -> 80 -> 40 ... -> 01.
  function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
    if (rc == 8'h36) return 8'h1b;
    if (rc == 8'h1b) return 8'h80;
    return rc >> 1;
  endfunction

endpackage

// File: rtl/inv_key_step.sv
// Combinational inverse of one AES-128 key-expansion round: (key, rcon) -> previous key.
module inv_key_step
  import aes_pkg::*;
(
  input  logic [KEY_LEN-1:0] key,
  input  logic [7:0]         rcon,
  output logic [KEY_LEN-1:0] prev_key
);

  logic [WORD_LEN-1:0] w0, w1, w2, w3;
  logic [WORD_LEN-1:0] p0, p1, p2, p3;

  assign {w0, w1, w2, w3} = key;

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon, 24'h0};

  assign prev_key = {p0, p1, p2, p3};

endmodule

// File: rtl/inv_key_expand.sv
// Iterative AES-128 inverse key scheduler emitting round keys 10..0.
// Build option INVKEY_FINAL_ONLY_EN: step internally and present only the round-0 key.
module inv_key_expand
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_LEN-1:0] data_in,
  input  logic               ready_in,
  output logic [KEY_LEN-1:0] data_out,
  output logic [3:0]         round_out,
  output logic               valid_out,
  output logic               busy,
  output logic               done,
  output state_e             state_dbg
);

  // Handshake: a key transfers on any cycle with valid_out=1 and ready_in=1;
  // while valid_out=1 and ready_in=0, data_out/round_out/valid_out hold.

`ifdef INVKEY_FINAL_ONLY_EN
  localparam logic VALID_ON_LOAD = 1'b0;
`else
  localparam logic VALID_ON_LOAD = 1'b1;
`endif

  state_e             state, state_nxt;
  logic [KEY_LEN-1:0] data_nxt, prev_key;
  logic [3:0]         round_nxt;
  logic [7:0]         rcon_q, rcon_nxt;
  logic               valid_nxt, busy_nxt, done_nxt;
  logic               step, finish;

  inv_key_step u_step (
    .key      (data_out),
    .rcon     (rcon_q),
    .prev_key (prev_key)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      data_out  <= '0;
      round_out <= '0;
      rcon_q    <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      data_out  <= data_nxt;
      round_out <= round_nxt;
      rcon_q    <= rcon_nxt;
      valid_out <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    round_nxt = round_out;
    rcon_nxt  = rcon_q;
    valid_nxt = valid_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;

    case (state)
      IDLE: begin
        // The done cycle still belongs to the finished sequence.
        if (start && !done) begin
          state_nxt = EMIT;
          data_nxt  = data_in;
          round_nxt = 4'(NUM_ROUNDS);
          rcon_nxt  = RCON_LAST;
          valid_nxt = VALID_ON_LOAD;
          busy_nxt  = 1'b1;
        end
      end
      EMIT: begin
`ifdef INVKEY_FINAL_ONLY_EN
        if (round_out != 4'd0) step = 1'b1;
        else if (valid_out && ready_in) finish = 1'b1;
`else
        if (valid_out && ready_in) begin
          if (round_out != 4'd0) step = 1'b1;
          else finish = 1'b1;
        end
`endif
        if (step) begin
          data_nxt  = prev_key;
          round_nxt = round_out - 4'd1;
          rcon_nxt  = rcon_prev(rcon_q);
`ifdef INVKEY_FINAL_ONLY_EN
          valid_nxt = (round_out == 4'd1);
`endif
        end
        if (finish) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule
